// File: rtl/spi_slave_fsm_burst.sv
// Purpose : SPI slave frame sequencer; command word (address + rw), then one data word, or back-to-back words in burst builds.
// Latency : all outputs registered; addr_we 1 clk after the command completes, sr_we READ_LAT+1 clk after addr_we/addr_inc, dm_we 1 clk after a data word completes.
// Backpr. : none; the master paces the frame with sclk_pos and ends it with cs, and the FSM follows or aborts.
//
// Optional feature: define SPI_FSM_BURST_EN to enable burst auto-increment (INC state, addr_inc).
//
// Ports:
//   clk         system clock, rising-edge active
//   reset       asynchronous active-high reset
//   cs          synchronised chip select, active-low
//   sclk_pos    one-clk pulse per SCLK rising edge
//   rw          shift-register LSB after the command word (1 = read)
//   sr_we       shift-register parallel load pulse
//   dm_we       data-memory write pulse
//   addr_we     address latch load pulse
//   addr_inc    address latch increment pulse (burst builds only, else 0)
//   miso_en     MISO driver enable level
//   busy        high unless idle in GET with an empty bit counter
//   frame_abort one-clk pulse when cs deasserts mid-frame

module spi_slave_fsm_burst #(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 8,
   parameter int READ_LAT = 1   // legal range 1..15
) (
   input  logic clk,
   input  logic reset,
   input  logic cs,
   input  logic sclk_pos,
   input  logic rw,
   output logic sr_we,
   output logic dm_we,
   output logic addr_we,
   output logic addr_inc,
   output logic miso_en,
   output logic busy,
   output logic frame_abort
);

   localparam int CMD_W = ADDR_W + 1;
   localparam int MAX_W = (CMD_W > DATA_W) ? CMD_W : DATA_W;
   localparam int CNT_W = $clog2(MAX_W) + 1;

   localparam logic [CNT_W-1:0] CMD_CNT  = CNT_W'(CMD_W);
   localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(DATA_W);
   // RD_WAIT exits when the latency counter reaches READ_LAT-1, giving
   // exactly READ_LAT cycles in that state.
   localparam logic [3:0]       LAT_LAST = 4'(READ_LAT - 1);

   typedef enum logic [3:0] {
      S_GET,
      S_GOT,
      S_RD_WAIT,
      S_LOAD,
      S_SHIFT_OUT,
      S_SHIFT_IN,
      S_COMMIT,
`ifdef SPI_FSM_BURST_EN
      S_INC,
`endif
      S_DONE
   } state_t;

   // Where a completed data word goes next.
`ifdef SPI_FSM_BURST_EN
   localparam state_t WORD_END = S_INC;
`else
   localparam state_t WORD_END = S_DONE;
`endif

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic [3:0]       lat_cnt, lat_cnt_nxt;
   logic             cnt_state;
   logic             mid_frame;

   logic sr_we_d, dm_we_d, addr_we_d, miso_en_d, busy_d, frame_abort_d;

`ifdef SPI_FSM_BURST_EN
   logic rw_q;       // frame direction, captured in GOT, steers INC
   logic addr_inc_d;
`endif

   // ------------------------------------------------------------------
   // State register, counters and registered outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= S_GET;
         count       <= '0;
         lat_cnt     <= '0;
         sr_we       <= 1'b0;
         dm_we       <= 1'b0;
         addr_we     <= 1'b0;
         miso_en     <= 1'b0;
         busy        <= 1'b0;
         frame_abort <= 1'b0;
`ifdef SPI_FSM_BURST_EN
         rw_q        <= 1'b0;
         addr_inc    <= 1'b0;
`endif
      end else begin
         state       <= state_nxt;
         count       <= count_nxt;
         lat_cnt     <= lat_cnt_nxt;
         sr_we       <= sr_we_d;
         dm_we       <= dm_we_d;
         addr_we     <= addr_we_d;
         miso_en     <= miso_en_d;
         busy        <= busy_d;
         frame_abort <= frame_abort_d;
`ifdef SPI_FSM_BURST_EN
         if (state == S_GOT) begin
            rw_q <= rw;
         end
         addr_inc    <= addr_inc_d;
`endif
      end
   end

`ifndef SPI_FSM_BURST_EN
   assign addr_inc = 1'b0;
`endif

   // ------------------------------------------------------------------
   // Next-state and counter logic
   // ------------------------------------------------------------------
   always_comb begin
      state_nxt = state;
      if (cs) begin
         // Deselect wins over every other transition.
         state_nxt = S_GET;
      end else begin
         case (state)
            S_GET:       if (count == CMD_CNT) state_nxt = S_GOT;
            S_GOT:       state_nxt = rw ? S_RD_WAIT : S_SHIFT_IN;
            S_RD_WAIT:   if (lat_cnt == LAT_LAST) state_nxt = S_LOAD;
            S_LOAD:      state_nxt = S_SHIFT_OUT;
            S_SHIFT_OUT: if (count == DATA_CNT) state_nxt = WORD_END;
            S_SHIFT_IN:  if (count == DATA_CNT) state_nxt = S_COMMIT;
            S_COMMIT:    state_nxt = WORD_END;
`ifdef SPI_FSM_BURST_EN
            S_INC:       state_nxt = rw_q ? S_RD_WAIT : S_SHIFT_IN;
`endif
            S_DONE:      state_nxt = S_DONE;
            default:     state_nxt = S_GET;
         endcase
      end

      cnt_state = (state == S_GET) || (state == S_SHIFT_OUT) ||
                  (state == S_SHIFT_IN);

      // Any transition (or a deselect) empties the bit counter, so every
      // counting state is entered with count == 0.
      count_nxt = count;
      if (cs || (state_nxt != state)) begin
         count_nxt = '0;
      end else if (cnt_state && sclk_pos) begin
         count_nxt = count + CNT_W'(1);
      end

      lat_cnt_nxt = '0;
      if ((state == S_RD_WAIT) && (state_nxt == S_RD_WAIT)) begin
         lat_cnt_nxt = lat_cnt + 4'd1;
      end
   end

   // ------------------------------------------------------------------
   // Output decode; values are registered, so they follow state_nxt and
   // appear in the same cycle the FSM occupies the corresponding state.
   // ------------------------------------------------------------------
   always_comb begin
      // A frame counts as in progress unless idle with no bits taken or
      // already finished. In burst builds a word boundary is a clean end.
      case (state)
         S_GET:       mid_frame = (count != '0);
         S_DONE:      mid_frame = 1'b0;
`ifdef SPI_FSM_BURST_EN
         S_SHIFT_IN,
         S_SHIFT_OUT: mid_frame = (count != '0);
`endif
         default:     mid_frame = 1'b1;
      endcase

      sr_we_d       = (state_nxt == S_LOAD);
      dm_we_d       = (state_nxt == S_COMMIT);
      addr_we_d     = (state_nxt == S_GOT);
      miso_en_d     = (state_nxt == S_SHIFT_OUT);
      busy_d        = !((state_nxt == S_GET) && (count_nxt == '0));
      frame_abort_d = cs && mid_frame;
`ifdef SPI_FSM_BURST_EN
      addr_inc_d    = (state_nxt == S_INC);
`endif
   end

endmodule
